seq_digit_adder: RTL and testbench
==================================

Name: seq_digit_adder

Overview:
Parametrised, multi-cycle successor to the 4-bit parallel adder (four_bit_adder). It computes S = A + B + C0 one DIGIT-wide slice per clock, least significant slice first, so a wide add needs only a narrow carry chain. Operands are captured on a start/busy/done handshake. The block reports carry-out and two's-complement overflow and is intended as the arithmetic unit for datapath labs.

Parameters:
WIDTH, 8, operand and sum width in bits; must be at least 2.
DIGIT, 4, bits added per clock; must divide WIDTH exactly. NDIG = WIDTH/DIGIT is the number of RUN cycles.

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous, active-high reset
start  input   1      request a new add; sampled only in IDLE
A      input   WIDTH  operand A; sampled in the cycle start is accepted
B      input   WIDTH  operand B; sampled in the cycle start is accepted
C0     input   1      carry-in; sampled in the cycle start is accepted
busy   output  1      high while in RUN
done   output  1      one-cycle pulse; S, CN and V are valid from this cycle
S      output  WIDTH  sum, registered
CN     output  1      carry-out of bit WIDTH-1, registered
V      output  1      signed overflow (carry into MSB XOR carry out of MSB), registered

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, done=0, S=0, CN=0, V=0; digit counter and internal operand/carry registers cleared. Reset overrides every other input.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k: latch A, B and C0 into internal registers; carry register = C0; digit index = 0; go to RUN. busy=1 from edge k.
- RUN, each edge: add operand digit[i] of A, digit[i] of B and the carry register (DIGIT+1 bits). Store the low DIGIT bits into slice i of an internal sum register. Update the carry register. Increment i.
- RUN, last digit (edge k+NDIG): S, CN and V are updated together from the internal result. The transition is RUN -> DONE, busy=0, done=1.
- DONE: done stays high for exactly one cycle, then the block returns to IDLE on the next edge. start is ignored in DONE, so the earliest re-accept is one cycle after done.
- Latency: done rises NDIG edges after the start edge. Throughput is one add every NDIG+2 cycles.
- S, CN and V change only on entry to DONE and hold their values until the next completion or reset. Partial sums are never visible on S.
- Overflow rule: c_msb_in = A[W-1] ^ B[W-1] ^ sum[W-1], using latched operands; V = c_msb_in ^ CN.
- start while in RUN or DONE: ignored, and the latched operands are unaffected.
- A, B and C0 may change freely after acceptance with no effect on the result.
- Wrap-around: the sum is modulo 2^WIDTH. The bit beyond the MSB appears only on CN.
- Reset during RUN: aborts the operation, no done pulse, outputs go to 0. A start accepted after reset behaves normally.
- WIDTH=DIGIT (NDIG=1) is legal: a single RUN cycle.

Test Plan:
1. Hold rst=1 for 2 cycles -> busy=0, done=0, S=0x00, CN=0, V=0.
2. WIDTH=8, DIGIT=4: A=0x33, B=0x33, C0=0, pulse start -> busy for 2 cycles; done exactly 2 edges after start; S=0x66, CN=0, V=0.
3. A=0x7F, B=0x01, C0=0 -> S=0x80, CN=0, V=1. A=0xFF, B=0xFF, C0=1 -> S=0xFF, CN=1, V=0 (this add carries across the digit boundary).
4. Start with A=0x0F, B=0x01, C0=0. While busy, apply start=1 with A=0xAA, B=0x55 -> second start ignored; S=0x10, CN=0. A single done pulse, and S holds 0x10 for 5 idle cycles.
5. Start with A=0xF0, B=0x20. Assert rst in the first RUN cycle -> no done pulse; S=0, CN=0, V=0. A new start with A=0x01, B=0x02 -> S=0x03.
6. WIDTH=4, DIGIT=4: A=0xB, B=0x7, C0=1 -> done 1 edge after start; S=0x3, CN=1, V=0. Also WIDTH=8, DIGIT=2: A=0x80, B=0x80 -> S=0x00, CN=1, V=1, done after 4 edges.

Source files
------------

// File: rtl/seq_digit_adder_if.sv
// ---------------------------------------------------------------------------
// seq_digit_adder_if
// Bundles the start/busy/done handshake, the operands and the registered
// results of seq_digit_adder.
//   start, A, B, C0 : request and operands, driven by the master
//   busy, done      : handshake status, driven by the adder
//   S, CN, V        : registered sum, carry-out and signed overflow
// ---------------------------------------------------------------------------
interface seq_digit_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             C0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             CN;
   logic             V;

   modport master (
      output start, A, B, C0,
      input  busy, done, S, CN, V
   );

   modport slave (
      input  start, A, B, C0,
      output busy, done, S, CN, V
   );
endinterface

// File: rtl/seq_digit_adder.sv
// ---------------------------------------------------------------------------
// seq_digit_adder
// Multi-cycle adder: S = A + B + C0, computed DIGIT bits per clock, least
// significant digit first. Operands are latched when start is accepted in
// IDLE; done pulses for one cycle when S/CN/V have been updated.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : seq_digit_adder_if.slave (start, A, B, C0 in; busy, done, S, CN, V out)
// WIDTH must be >= 2 and a multiple of DIGIT.
// ---------------------------------------------------------------------------
module seq_digit_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   seq_digit_adder_if.slave    bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] sum_q, sum_d;   // partial sum, never visible on S
   logic [WIDTH-1:0] s_q, s_d;
   logic             cn_q, cn_d;
   logic             v_q, v_d;
   logic [DIGIT:0]   dsum;           // one digit plus its carry-out

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         s_q     <= '0;
         cn_q    <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         s_q     <= s_d;
         cn_q    <= cn_d;
         v_q     <= v_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      s_d     = s_q;
      cn_d    = cn_q;
      v_d     = v_q;

      dsum = {1'b0, a_q[int'(idx_q)*DIGIT +: DIGIT]}
           + {1'b0, b_q[int'(idx_q)*DIGIT +: DIGIT]}
           + {{DIGIT{1'b0}}, carry_q};

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.A;
               b_d     = bus.B;
               carry_d = bus.C0;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[int'(idx_q)*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
            carry_d = dsum[DIGIT];
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == IDXW'(NDIG - 1)) begin
               // Publish the complete result in one step. The carry into
               // the MSB is recovered from the MSB's own sum bit.
               s_d     = sum_d;
               cn_d    = dsum[DIGIT];
               v_d     = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_d[WIDTH-1] ^ dsum[DIGIT];
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.S    = s_q;
   assign bus.CN   = cn_q;
   assign bus.V    = v_q;
endmodule

// File: tb/tb_seq_digit_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_digit_adder
// Exercises three configurations of seq_digit_adder:
//   cfg 0 : WIDTH=8, DIGIT=4   cfg 1 : WIDTH=4, DIGIT=4   cfg 2 : WIDTH=8, DIGIT=2
// Expected results come from plain integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_seq_digit_adder;
   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   seq_digit_adder_if #(.WIDTH(8)) if0 ();
   seq_digit_adder_if #(.WIDTH(4)) if1 ();
   seq_digit_adder_if #(.WIDTH(8)) if2 ();

   seq_digit_adder #(.WIDTH(8), .DIGIT(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   seq_digit_adder #(.WIDTH(4), .DIGIT(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   seq_digit_adder #(.WIDTH(8), .DIGIT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_in(input int cfg, input logic st, input logic [7:0] a,
                           input logic [7:0] b, input logic c0);
      case (cfg)
         0: begin if0.start = st; if0.A = a; if0.B = b; if0.C0 = c0; end
         1: begin if1.start = st; if1.A = a[3:0]; if1.B = b[3:0]; if1.C0 = c0; end
         default: begin if2.start = st; if2.A = a; if2.B = b; if2.C0 = c0; end
      endcase
   endtask

   task automatic read_out(input int cfg, output logic busy, output logic done,
                           output logic [7:0] s, output logic cn, output logic v);
      case (cfg)
         0: begin busy = if0.busy; done = if0.done; s = if0.S; cn = if0.CN; v = if0.V; end
         1: begin busy = if1.busy; done = if1.done; s = {4'b0, if1.S}; cn = if1.CN; v = if1.V; end
         default: begin busy = if2.busy; done = if2.done; s = if2.S; cn = if2.CN; v = if2.V; end
      endcase
   endtask

   // Waits (bounded) for done; returns edges counted after the start edge.
   // Checks that S does not change while the add is in progress.
   task automatic wait_done(input int cfg, input string tag, output int cycles);
      logic busy, done, cn, v;
      logic [7:0] s, s_prev;
      read_out(cfg, busy, done, s_prev, cn, v);
      cycles = 0;
      done   = 1'b0;
      while (!done && cycles < 20) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         read_out(cfg, busy, done, s, cn, v);
         if (!done) check({tag, "_S_hidden"}, {24'b0, s}, {24'b0, s_prev});
      end
   endtask

   task automatic do_add(input int cfg, input logic [7:0] a, input logic [7:0] b,
                         input logic c0, input string tag);
      int w, ndig, full, sa, sb, ssum, cycles;
      logic [7:0] am, bm, exp_s;
      logic exp_cn, exp_v, busy, done, cn, v;
      logic [7:0] s;
      w    = (cfg == 1) ? 4 : 8;
      ndig = (cfg == 0) ? 2 : (cfg == 1) ? 1 : 4;
      am   = a & 8'((1 << w) - 1);
      bm   = b & 8'((1 << w) - 1);
      full   = int'(am) + int'(bm) + int'(c0);
      exp_s  = 8'(full % (1 << w));
      exp_cn = (full >= (1 << w));
      sa     = (int'(am) >= (1 << (w - 1))) ? int'(am) - (1 << w) : int'(am);
      sb     = (int'(bm) >= (1 << (w - 1))) ? int'(bm) - (1 << w) : int'(bm);
      ssum   = sa + sb + int'(c0);
      exp_v  = (ssum > (1 << (w - 1)) - 1) || (ssum < -(1 << (w - 1)));

      @(negedge clk);
      drive_in(cfg, 1'b1, a, b, c0);
      @(posedge clk);
      @(negedge clk);
      // Operands may change freely once accepted.
      drive_in(cfg, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      read_out(cfg, busy, done, s, cn, v);
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      wait_done(cfg, tag, cycles);
      read_out(cfg, busy, done, s, cn, v);
      check({tag, "_latency"}, cycles, ndig);
      check({tag, "_S"}, {24'b0, s}, {24'b0, exp_s});
      check({tag, "_CN"}, {31'b0, cn}, {31'b0, exp_cn});
      check({tag, "_V"}, {31'b0, v}, {31'b0, exp_v});
      @(posedge clk);
      @(negedge clk);
      read_out(cfg, busy, done, s, cn, v);
      check({tag, "_done_pulse"}, {30'b0, busy, done}, 32'd0);
      $display("[TB] %s cfg=%0d A=%0h B=%0h C0=%0d -> S=%0h CN=%0d V=%0d (model S=%0h CN=%0d V=%0d)",
               tag, cfg, am, bm, c0, s, cn, v, exp_s, exp_cn, exp_v);
   endtask

   initial begin
      logic busy, done, cn, v;
      logic [7:0] s;
      int cycles, done_seen;

      rst = 1'b1;
      for (int c = 0; c < 3; c++) drive_in(c, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         read_out(c, busy, done, s, cn, v);
         check($sformatf("reset_cfg%0d", c), {21'b0, busy, done, s, cn, v}, 32'd0);
      end
      rst = 1'b0;

      // Directed adds, WIDTH=8 DIGIT=4
      do_add(0, 8'h33, 8'h33, 1'b0, "add_33_33");
      do_add(0, 8'h7F, 8'h01, 1'b0, "add_7F_01");
      do_add(0, 8'hFF, 8'hFF, 1'b1, "add_FF_FF_c");

      // Start while busy is ignored; S held afterwards
      @(negedge clk);
      drive_in(0, 1'b1, 8'h0F, 8'h01, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive_in(0, 1'b1, 8'hAA, 8'h55, 1'b0);
      wait_done(0, "ign", cycles);
      read_out(0, busy, done, s, cn, v);
      check("ign_latency", cycles, 2);
      check("ign_S", {24'b0, s}, 32'h10);
      check("ign_CN", {31'b0, cn}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      drive_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
      read_out(0, busy, done, s, cn, v);
      check("ign_single_done", {30'b0, busy, done}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         read_out(0, busy, done, s, cn, v);
         check($sformatf("ign_hold%0d", i), {22'b0, busy, done, s}, 32'h10);
      end
      $display("[TB] ignore-start cfg=0 S=%0h after 5 idle cycles", s);

      // Reset during RUN aborts the add
      @(negedge clk);
      drive_in(0, 1'b1, 8'hF0, 8'h20, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      read_out(0, busy, done, s, cn, v);
      check("abort_outputs", {21'b0, busy, done, s, cn, v}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         read_out(0, busy, done, s, cn, v);
         if (done) done_seen++;
      end
      check("abort_no_done", done_seen, 0);
      $display("[TB] reset-abort cfg=0 done pulses after abort=%0d", done_seen);
      do_add(0, 8'h01, 8'h02, 1'b0, "after_abort");

      // Other geometries
      do_add(1, 8'h0B, 8'h07, 1'b1, "w4_B_7_c");
      do_add(2, 8'h80, 8'h80, 1'b0, "d2_80_80");

      // Randomised adds on every configuration
      for (int i = 0; i < 12; i++) begin
         for (int c = 0; c < 3; c++) begin
            do_add(c, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
